// File: rtl/aes_enc_iter_pkg.sv
// aes_enc_iter_pkg: AES-128 constants, the byte-state and key-schedule types,
// the FIPS-197 S-box and pure round-transform functions. These are shared by
// the encryption core and intended for reuse by a future decryption core.
// State byte k = 4*col + row; byte 0 is the MSB of the 128-bit block.
// Key word w = rnd*NB + col; row r of a word is bits [31-8r -: 8].
package aes_enc_iter_pkg;

  localparam int NB = 4;
  localparam int NR = 10;
  localparam int NK = 4;
  localparam int NW = NB * (NR + 1);

  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef logic [0:4*NB-1][7:0] state_t;
  typedef logic [0:NB-1][31:0]  rkey_t;
  typedef logic [0:NW-1][31:0]  kw_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t r;
    for (int k = 0; k < 4*NB; k++) r[k] = SBOX[s[k]];
    return r;
  endfunction

  // Row i rotates left by i columns.
  function automatic state_t shift_rows(input state_t s);
    state_t r;
    for (int j = 0; j < NB; j++)
      for (int i = 0; i < 4; i++)
        r[4*j+i] = s[4*((j+i)%NB)+i];
    return r;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int j = 0; j < NB; j++) begin
      a0 = s[4*j];
      a1 = s[4*j+1];
      a2 = s[4*j+2];
      a3 = s[4*j+3];
      r[4*j]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[4*j+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[4*j+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[4*j+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic rkey_t round_key(input kw_t w, input logic [3:0] rnd);
    rkey_t rk;
    for (int j = 0; j < NB; j++) rk[j] = w[int'(rnd)*NB + j];
    return rk;
  endfunction

  function automatic state_t xor_rkey(input state_t s, input rkey_t rk);
    state_t r;
    for (int j = 0; j < NB; j++)
      for (int i = 0; i < 4; i++)
        r[4*j+i] = s[4*j+i] ^ rk[j][8*(3-i) +: 8];
    return r;
  endfunction

  function automatic state_t add_rkey(input state_t s, input kw_t w, input logic [3:0] rnd);
    return xor_rkey(s, round_key(w, rnd));
  endfunction

endpackage

// File: rtl/aes_enc_iter_round_dp.sv
// aes_round_dp: one combinational AES encryption round.
//   state  in  current 16-byte state
//   rkey   in  four round-key words for this round
//   last   in  final round: MixColumns is skipped
//   next   out state after SubBytes, ShiftRows, [MixColumns], AddRoundKey
module aes_round_dp
  import aes_enc_iter_pkg::*;
(
  input  state_t     state,
  input  rkey_t      rkey,
  input  logic       last,
  output state_t     next
);

  state_t sr;

  always_comb begin
    sr   = shift_rows(sub_bytes(state));
    next = xor_rkey(last ? sr : mix_columns(sr), rkey);
  end

endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryption core, one round per clock.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     plaintext handshake, in_state is the block
//   key_word              expanded key, held stable until the block is output
//   flush                 synchronous abort, wins over both handshakes
//   out_valid/out_ready   ciphertext handshake, out_state is the block
//   busy                  high while a block is in flight or waiting to drain
//   round_idx             round counter, debug only
//
// state | meaning
// IDLE  | empty, ready for a block
// ROUND | applying rounds 1..NR, one per edge
// DONE  | ciphertext held until out_ready
module aes_enc_iter
  import aes_enc_iter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  state_t            in_state,
  input  kw_t               key_word,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output state_t            out_state,
  output logic              busy,
  output logic [3:0]        round_idx
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t       fsm_q, fsm_d;
  state_t     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  state_t     dp_next;
  logic       accept;

  aes_round_dp u_round_dp (
    .state (state_q),
    .rkey  (round_key(key_word, rnd_q)),
    .last  (rnd_q == LAST_RND),
    .next  (dp_next)
  );

  // DONE with out_ready lets the next block land on the output edge.
  assign in_ready  = !flush && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm_q == DONE);
  assign out_state = state_q;
  assign busy      = (fsm_q != IDLE);
  assign round_idx = rnd_q;

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    if (flush) begin
      fsm_d = IDLE;
      rnd_d = 4'd0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            state_d = add_rkey(in_state, key_word, 4'd0);
            rnd_d   = 4'd1;
            fsm_d   = ROUND;
          end
        end
        ROUND: begin
          state_d = dp_next;
          if (rnd_q == LAST_RND) fsm_d = DONE;
          else                   rnd_d = rnd_q + 4'd1;
        end
        DONE: begin
          if (out_ready) begin
            if (accept) begin
              state_d = add_rkey(in_state, key_word, 4'd0);
              rnd_d   = 4'd1;
              fsm_d   = ROUND;
            end else begin
              rnd_d = 4'd0;
              fsm_d = IDLE;
            end
          end
        end
        default: begin
          fsm_d = IDLE;
          rnd_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
module tb_aes_enc_iter;
  import aes_enc_iter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  state_t     in_state = '0;
  kw_t        key_word = '0;
  logic       in_ready, out_valid, busy;
  state_t     out_state;
  logic [3:0] round_idx;

  aes_enc_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .key_word  (key_word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  int checks = 0;
  int passes = 0;
  logic [127:0] exp_q[$];
  kw_t kw_c1, kw_b;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic kw_t expand(input logic [127:0] key);
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    kw_t         r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < NW; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < NW; i++) r[i] = w[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, 10);
  endtask

  // Scoreboard: every completed output handshake pops one expected block.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() > 0) chk("ciphertext", out_state, exp_q.pop_front());
      else begin
        checks++;
        $error("FAIL sb_underflow observed=%h expected=no output", out_state);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   n;
    kw_c1 = expand(KEY_C1);
    kw_b  = expand(KEY_B);

    repeat (3) tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_round_idx", round_idx, 0);
    rst_n = 1'b1;
    tick();
    chk("reset_in_ready", in_ready, 1);

    // Reset mid-block aborts immediately.
    in_state = PT_C1; key_word = kw_c1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("midblk_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_round_idx", round_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", in_ready, 1);

    // FIPS-197 C.1 with latency measurement.
    in_state = PT_C1; key_word = kw_c1; in_valid = 1'b1;
    exp_q.push_back(CT_C1);
    tick();
    in_valid = 1'b0;
    wait_out("c1_latency");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("c1_idle_busy", busy, 0);

    // Back-to-back: second block accepted on the first block's output edge.
    out_ready = 1'b1;
    in_state = PT_C1; key_word = kw_c1; in_valid = 1'b1;
    exp_q.push_back(CT_C1);
    tick();
    in_state = PT_B;
    wait_out("b2b_latency1");
    key_word = kw_b;
    exp_q.push_back(CT_B);
    chk("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_round_idx", round_idx, 1);
    chk("b2b_busy", busy, 1);
    wait_out("b2b_latency2");
    tick();
    chk("b2b_drained", out_valid, 0);

    // Backpressure: out_ready low for 7 cycles.
    out_ready = 1'b0;
    in_state = PT_B; key_word = kw_b; in_valid = 1'b1;
    exp_q.push_back(CT_B);
    tick();
    in_valid = 1'b0;
    wait_out("bp_latency");
    for (int c = 0; c < 7; c++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_state", out_state, CT_B);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    chk("bp_after_out_valid", out_valid, 0);
    chk("bp_after_round_idx", round_idx, 0);

    // Flush at round 5.
    in_state = PT_C1; key_word = kw_c1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd5 && n < 40) begin
      tick();
      n++;
    end
    chk("flush_reach_rnd5", round_idx, 5);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_round_idx", round_idx, 0);
    seen = out_valid;
    repeat (15) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_output", seen, 0);

    // Flush beats accept in IDLE.
    flush = 1'b1; in_state = PT_B; key_word = kw_b; in_valid = 1'b1;
    #1;
    chk("flush_idle_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_no_accept", busy, 0);

    // App. B after flush.
    in_state = PT_B; key_word = kw_b; in_valid = 1'b1;
    exp_q.push_back(CT_B);
    tick();
    in_valid = 1'b0;
    wait_out("postflush_latency");
    tick();
    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
